// File: rtl/regfile_debug_reader.sv
// Debug-port reader for the register file: drives radd_debug/clk_debug, captures dout_debug and
// hands each word downstream over a valid/ready handshake, either for one address or a full scan.
module regfile_debug_reader #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 31
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              single,
    input  logic [ADDR_W-1:0] sel_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] radd_debug,
    output logic              clk_debug,
    input  logic [DATA_W-1:0] dout_debug,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StFall,
        StHold
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                single_q, single_d;
    logic                clk_debug_q, clk_debug_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                last_word;

    assign last_word = single_q || (addr_q == LastAddr);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        single_d    = single_q;
        clk_debug_d = 1'b0;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        // abort beats both start in IDLE and a same-cycle handshake in HOLD
        if (abort) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d  = StSetup;
                        single_d = single;
                        addr_d   = single ? sel_addr : FirstAddr;
                    end
                end
                StSetup: begin
                    clk_debug_d = 1'b1;
                    state_d     = StPulse;
                end
                StPulse: begin
                    state_d = StFall;
                end
                StFall: begin
                    out_data_d  = dout_debug;
                    out_addr_d  = addr_q;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (last_word) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = StSetup;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            single_q    <= 1'b0;
            clk_debug_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            single_q    <= single_d;
            clk_debug_q <= clk_debug_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // radd_debug is the working address itself, so it holds the last address in IDLE
    assign radd_debug = addr_q;
    assign clk_debug  = clk_debug_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
